// File: rtl/pla_vector_sequencer.sv
// Sequential harness around a flattened combinational PLA netlist.
// Accepts one input vector at a time over valid/ready and drives it onto the
// netlist inputs from a register. It waits a settle window, samples the
// single netlist output, and returns (vector, y) over valid/ready. Every
// returned result is folded into a 16-bit MISR signature and counted.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    input vector handshake; in_vec is the vector
//   x_out                registered drive to netlist inputs x0..x(N_IN-1)
//   y_in                 netlist output y0 (combinational from x_out)
//   out_valid/out_ready  result handshake; out_vec/out_y is the result
//   clear                synchronous clear of sig/vec_cnt/ones_cnt
//   sig                  MISR signature over handshaked out_y
//   vec_cnt, ones_cnt    saturating result and ones counters
module pla_vector_sequencer #(
    parameter int unsigned N_IN      = 14,
    parameter int unsigned SETTLE    = 1,
    parameter logic [15:0] MISR_POLY = 16'hB400
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_vec,
    output logic [N_IN-1:0] x_out,
    input  logic            y_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N_IN-1:0] out_vec,
    output logic            out_y,
    input  logic            clear,
    output logic [15:0]     sig,
    output logic [15:0]     vec_cnt,
    output logic [15:0]     ones_cnt
);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e          state_q, state_d;
    logic [7:0]      settle_q, settle_d;
    logic [N_IN-1:0] x_q, x_d;
    logic [N_IN-1:0] out_vec_q, out_vec_d;
    logic            out_y_q, out_y_d;
    logic            out_valid_q, out_valid_d;
    logic [15:0]     sig_q, sig_d;
    logic [15:0]     vec_cnt_q, vec_cnt_d;
    logic [15:0]     ones_cnt_q, ones_cnt_d;
    logic            handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            settle_q    <= 8'd0;
            x_q         <= '0;
            out_vec_q   <= '0;
            out_y_q     <= 1'b0;
            out_valid_q <= 1'b0;
            sig_q       <= 16'd0;
            vec_cnt_q   <= 16'd0;
            ones_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            x_q         <= x_d;
            out_vec_q   <= out_vec_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
            sig_q       <= sig_d;
            vec_cnt_q   <= vec_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        x_d         = x_q;
        out_vec_d   = out_vec_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d       = in_vec;
                    out_vec_d = in_vec;
                    settle_d  = 8'(SETTLE);
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (settle_q != 8'd0) begin
                    settle_d = settle_q - 8'd1;
                end else begin
                    out_y_d     = y_in;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign handshake = (state_q == StHold) && out_ready;

    // Clear wins over a coincident handshake: that result is not accumulated.
    always_comb begin
        sig_d      = sig_q;
        vec_cnt_d  = vec_cnt_q;
        ones_cnt_d = ones_cnt_q;
        if (clear) begin
            sig_d      = 16'd0;
            vec_cnt_d  = 16'd0;
            ones_cnt_d = 16'd0;
        end else if (handshake) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0) ^ {15'h0, out_y_q};
            if (vec_cnt_q != 16'hFFFF) begin
                vec_cnt_d = vec_cnt_q + 16'd1;
            end
            if (out_y_q && (ones_cnt_q != 16'hFFFF)) begin
                ones_cnt_d = ones_cnt_q + 16'd1;
            end
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign x_out     = x_q;
    assign out_vec   = out_vec_q;
    assign out_y     = out_y_q;
    assign out_valid = out_valid_q;
    assign sig       = sig_q;
    assign vec_cnt   = vec_cnt_q;
    assign ones_cnt  = ones_cnt_q;

endmodule
